// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control blocks.
// Holds the sequencer state encoding and the default bus widths.
package cpu_pkg;

  localparam int NB_REG_ADDRESS = 5;
  localparam int NB_CYCLE_COUNT = 32;
  localparam int NB_STATE       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/load_use_detector.sv
// Detects a load in ID/EX whose destination is read by the instruction in IF/ID.
// Register 0 is never a real dependency.
module load_use_detector #(
  parameter int NB_REG_ADDRESS = cpu_pkg::NB_REG_ADDRESS
) (
  input  logic                      i_mem_read_id_ex,
  input  logic [NB_REG_ADDRESS-1:0] i_rt_id_ex,
  input  logic [NB_REG_ADDRESS-1:0] i_rs_if_id,
  input  logic [NB_REG_ADDRESS-1:0] i_rt_if_id,
  output logic                      o_stall
);
  import cpu_pkg::*;

  logic w_dest_valid;
  logic w_src_match;

  assign w_dest_valid = (i_rt_id_ex != '0);
  assign w_src_match  = (i_rt_id_ex == i_rs_if_id) || (i_rt_id_ex == i_rt_if_id);
  assign o_stall      = i_mem_read_id_ex && w_dest_valid && w_src_match;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Run/step/halt sequencer plus load-use stall and branch flush gating for the pipeline.
// state  | meaning: IDLE waiting for debug | RUN free-running | STEP one enabled cycle | HALTED program done
module pipeline_hazard_controller #(
  parameter int NB_REG_ADDRESS = cpu_pkg::NB_REG_ADDRESS,
  parameter int NB_CYCLE_COUNT = cpu_pkg::NB_CYCLE_COUNT,
  parameter int NB_STATE       = cpu_pkg::NB_STATE
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_run,
  input  logic                      i_step,
  input  logic                      i_clear,
  input  logic                      i_halt_wb,
  input  logic [NB_REG_ADDRESS-1:0] i_rs_if_id,
  input  logic [NB_REG_ADDRESS-1:0] i_rt_if_id,
  input  logic [NB_REG_ADDRESS-1:0] i_rt_id_ex,
  input  logic                      i_mem_read_id_ex,
  input  logic                      i_branch_taken,
  output logic                      o_pipeline_enable,
  output logic                      o_pc_write,
  output logic                      o_if_id_write,
  output logic                      o_id_ex_bubble,
  output logic                      o_if_id_flush,
  output logic                      o_halted,
  output logic [NB_STATE-1:0]       o_state,
  output logic [NB_CYCLE_COUNT-1:0] o_cycle_count
);
  import cpu_pkg::*;

  state_t                    r_state;
  logic [NB_CYCLE_COUNT-1:0] r_cycle_count;
  logic                      w_enable;
  logic                      w_stall;

  load_use_detector #(
    .NB_REG_ADDRESS(NB_REG_ADDRESS)
  ) u_load_use (
    .i_mem_read_id_ex(i_mem_read_id_ex),
    .i_rt_id_ex      (i_rt_id_ex),
    .i_rs_if_id      (i_rs_if_id),
    .i_rt_if_id      (i_rt_if_id),
    .o_stall         (w_stall)
  );

  assign w_enable = (r_state == ST_RUN) || (r_state == ST_STEP);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cycle_count <= '0;
    end else if (i_clear) begin
      r_state       <= ST_IDLE;
      r_cycle_count <= '0;
    end else begin
      // Stall cycles still count: they are enabled cycles, just without PC progress.
      if (w_enable && (r_cycle_count != '1))
        r_cycle_count <= r_cycle_count + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_run)       r_state <= ST_RUN;
          else if (i_step) r_state <= ST_STEP;
        end
        ST_RUN: begin
          if (i_halt_wb) r_state <= ST_HALTED;
        end
        ST_STEP:   r_state <= i_halt_wb ? ST_HALTED : ST_IDLE;
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pipeline_enable = w_enable;
  assign o_pc_write        = w_enable && !w_stall;
  assign o_if_id_write     = w_enable && !w_stall;
  assign o_id_ex_bubble    = w_enable && w_stall;
  assign o_if_id_flush     = w_enable && i_branch_taken && !w_stall;
  assign o_halted          = (r_state == ST_HALTED);
  assign o_state           = NB_STATE'(r_state);
  assign o_cycle_count     = r_cycle_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized checks of the pipeline hazard controller against a behavioural model.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0, step = 1'b0, clear = 1'b0, halt = 1'b0;
  logic [4:0] rs = '0, rt_if = '0, rt_ex = '0;
  logic       mem_rd = 1'b0, br = 1'b0;

  logic        en, pcw, ifw, bub, fl, hlt;
  logic [1:0]  st;
  logic [31:0] cnt;
  logic        en_s, pcw_s, ifw_s, bub_s, fl_s, hlt_s;
  logic [1:0]  st_s;
  logic [3:0]  cnt_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .i_clock(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_clear(clear),
    .i_halt_wb(halt), .i_rs_if_id(rs), .i_rt_if_id(rt_if), .i_rt_id_ex(rt_ex),
    .i_mem_read_id_ex(mem_rd), .i_branch_taken(br),
    .o_pipeline_enable(en), .o_pc_write(pcw), .o_if_id_write(ifw),
    .o_id_ex_bubble(bub), .o_if_id_flush(fl), .o_halted(hlt),
    .o_state(st), .o_cycle_count(cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  pipeline_hazard_controller #(.NB_CYCLE_COUNT(4)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_clear(clear),
    .i_halt_wb(halt), .i_rs_if_id(rs), .i_rt_if_id(rt_if), .i_rt_id_ex(rt_ex),
    .i_mem_read_id_ex(mem_rd), .i_branch_taken(br),
    .o_pipeline_enable(en_s), .o_pc_write(pcw_s), .o_if_id_write(ifw_s),
    .o_id_ex_bubble(bub_s), .o_if_id_flush(fl_s), .o_halted(hlt_s),
    .o_state(st_s), .o_cycle_count(cnt_s)
  );

  // Model: mode 0 idle, 1 run, 2 step, 3 halted; counts as plain integers.
  int    m_mode = 0;
  longint m_cnt = 0;
  longint m_cnt_s = 0;
  bit    m_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_cnt_s = 0;
    end else if (clear) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_cnt_s = 0;
    end else begin
      m_en = (m_mode == 1) || (m_mode == 2);
      if (m_en) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
      end
      if (m_mode == 0)      m_mode = run ? 1 : (step ? 2 : 0);
      else if (m_mode == 1) m_mode = halt ? 3 : 1;
      else if (m_mode == 2) m_mode = halt ? 3 : 0;
    end
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit e_en, e_stall;
  always @(negedge clk) begin
    e_en    = (m_mode == 1) || (m_mode == 2);
    e_stall = mem_rd && (rt_ex != 0) && ((rt_ex == rs) || (rt_ex == rt_if));
    cmp("state",        st,   m_mode);
    cmp("enable",       en,   e_en);
    cmp("pc_write",     pcw,  e_en && !e_stall);
    cmp("if_id_write",  ifw,  e_en && !e_stall);
    cmp("bubble",       bub,  e_en && e_stall);
    cmp("flush",        fl,   e_en && br && !e_stall);
    cmp("halted",       hlt,  m_mode == 3);
    cmp("count",        cnt,  m_cnt);
    cmp("sat_state",    st_s, m_mode);
    cmp("sat_enable",   en_s, e_en);
    cmp("sat_count",    cnt_s, m_cnt_s);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    #1;
    cmp("lit_reset_state", st, 0);
    cmp("lit_reset_count", cnt, 0);
    cmp("lit_reset_enable", en, 0);
    tick();

    // Run, five enabled edges, then halt.
    run = 1'b1; tick(); run = 1'b0;
    cmp("lit_run_state", st, 1);
    cmp("lit_run_enable", en, 1);
    repeat (5) tick();
    cmp("lit_run_count5", cnt, 5);
    halt = 1'b1; tick(); halt = 1'b0;
    cmp("lit_halted", hlt, 1);
    cmp("lit_halt_enable", en, 0);
    repeat (3) tick();
    cmp("lit_halt_count_frozen", cnt, 6);

    run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
    cmp("lit_halted_ignores_run", st, 3);
    clear = 1'b1; tick(); clear = 1'b0;
    cmp("lit_clear_state", st, 0);
    cmp("lit_clear_count", cnt, 0);

    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      cmp("lit_step_enable", en, 1);
      tick();
      cmp("lit_step_back_idle", st, 0);
      repeat (2) tick();
    end
    cmp("lit_step_count3", cnt, 3);

    run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
    cmp("lit_run_wins", st, 1);

    mem_rd = 1'b1; rt_ex = 5'd5; rs = 5'd5; rt_if = 5'd0; #1;
    cmp("lit_lu_pc_write", pcw, 0);
    cmp("lit_lu_bubble", bub, 1);
    tick();
    rt_ex = 5'd0; rs = 5'd0; #1;
    cmp("lit_r0_no_stall", pcw, 1);
    tick();
    mem_rd = 1'b0; br = 1'b1; #1;
    cmp("lit_branch_flush", fl, 1);
    tick();
    mem_rd = 1'b1; rt_ex = 5'd7; rt_if = 5'd7; #1;
    cmp("lit_branch_stalled_flush", fl, 0);
    cmp("lit_branch_stalled_bubble", bub, 1);
    tick();
    mem_rd = 1'b0; #1;
    cmp("lit_branch_then_flush", fl, 1);
    tick();
    br = 1'b0; rt_ex = '0; rt_if = '0;

    clear = 1'b1; tick(); clear = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    repeat (12) tick();
    cmp("lit_count12", cnt, 12);
    #2; rst = 1'b1; #1;
    cmp("lit_async_count", cnt, 0);
    cmp("lit_async_enable", en, 0);
    cmp("lit_async_pc_write", pcw, 0);
    tick(); rst = 1'b0;

    run = 1'b1; tick(); run = 1'b0;
    repeat (20) tick();
    cmp("lit_sat_count", cnt_s, 15);
    cmp("lit_wide_count", cnt, 20);

    for (int i = 0; i < 3000; i++) begin
      run    = ($urandom_range(0, 7) == 0);
      step   = ($urandom_range(0, 5) == 0);
      clear  = ($urandom_range(0, 40) == 0);
      halt   = ($urandom_range(0, 25) == 0);
      mem_rd = $urandom_range(0, 1);
      rt_ex  = 5'($urandom_range(0, 7));
      rs     = 5'($urandom_range(0, 7));
      rt_if  = 5'($urandom_range(0, 7));
      br     = ($urandom_range(0, 2) == 0);
      rst    = ($urandom_range(0, 300) == 0);
      tick();
    end
    rst = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0; halt = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequences the 5-stage MIPS pipeline that the forwarding unit serves. It has a run/step/halt FSM, driven by the debug unit, which gates every pipeline register. It also detects the hazards that forwarding cannot resolve:
- load-use: stall plus bubble;
- taken branch/jump: IF/ID flush.

It sits beside the forwarding unit in the top-level datapath and drives the PC, IF/ID and ID/EX write/flush controls. It also exposes a cycle counter and a halted status to the debug unit.

Parameters:
NB_REG_ADDRESS, 5, register-address width
NB_CYCLE_COUNT, 32, width of executed-cycle counter
NB_STATE, 2, state encoding width

Ports:
i_clock  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_run  input  1  pulse: enter continuous execution
i_step  input  1  pulse: execute exactly one clock cycle
i_clear  input  1  pulse: return to IDLE, zero counter
i_halt_wb  input  1  HALT instruction is in MEM/WB this cycle
i_rs_if_id  input  NB_REG_ADDRESS  rs of instruction in IF/ID
i_rt_if_id  input  NB_REG_ADDRESS  rt of instruction in IF/ID
i_rt_id_ex  input  NB_REG_ADDRESS  load destination (rt) in ID/EX
i_mem_read_id_ex  input  1  instruction in ID/EX is a load
i_branch_taken  input  1  branch/jump resolved taken in ID
o_pipeline_enable  output  1  global write enable for all pipeline registers
o_pc_write  output  1  PC update enable
o_if_id_write  output  1  IF/ID register write enable
o_id_ex_bubble  output  1  zero ID/EX control signals (insert NOP)
o_if_id_flush  output  1  clear IF/ID to NOP
o_halted  output  1  program finished
o_state  output  NB_STATE  current FSM state
o_cycle_count  output  NB_CYCLE_COUNT  number of enabled cycles

Behaviour:
- Clock and reset: one clock, i_clock. Reset i_reset is asynchronous and active-high.
- Reset values:
  - state = IDLE and o_cycle_count = 0.
  - All outputs 0, including o_pipeline_enable, o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush and o_halted.
- FSM states (registered): IDLE=0, RUN=1, STEP=2, HALTED=3.
  - IDLE: i_run goes to RUN; otherwise i_step goes to STEP. i_run wins if both arrive in the same cycle.
  - RUN: i_halt_wb goes to HALTED. i_run and i_step are ignored.
  - STEP: i_halt_wb goes to HALTED; otherwise the FSM returns to IDLE unconditionally after one cycle.
  - HALTED: i_run and i_step are ignored. The FSM stays here until i_clear or reset.
  - i_clear in any state goes to IDLE and zeroes the counter next edge. It has priority over every other transition.
- o_pipeline_enable = (state==RUN || state==STEP), decoded combinationally from the registered state.
  - Enable therefore rises the cycle after i_run/i_step is sampled.
  - A single step gives exactly one enabled cycle.
- o_halted = (state==HALTED). Enable falls the cycle after i_halt_wb is sampled.
- i_halt_wb is only acted on while enabled; it is ignored in IDLE.
- Load-use stall, combinational: stall = i_mem_read_id_ex && i_rt_id_ex!=0 && (i_rt_id_ex==i_rs_if_id || i_rt_id_ex==i_rt_if_id).
- While enabled:
  - o_pc_write = !stall
  - o_if_id_write = !stall
  - o_id_ex_bubble = stall
  - o_if_id_flush = i_branch_taken && !stall. Stall has priority: a branch depending on a load waits one cycle, then flushes.
- While disabled: o_pc_write, o_if_id_write, o_id_ex_bubble and o_if_id_flush are all 0.
- A stall lasts exactly one enabled cycle, because the bubble removes the load match on the next edge.
- In STEP, a stall consumes the step and the next i_step proceeds.
- o_cycle_count increments on each edge where o_pipeline_enable=1, stall cycles included. It saturates at all-ones and does not wrap.
- Reset mid-RUN: immediate IDLE, counter 0, enable 0 asynchronously.

Decomposition:
- Shared package cpu_pkg:
  - state encodings IDLE/RUN/STEP/HALTED;
  - NB_REG_ADDRESS;
  - NB_CYCLE_COUNT.
- One natural sub-module, load_use_detector: the combinational stall equation. The FSM, gating and counter stay in the top module.

Test Plan:
1. Reset, then i_run pulse at cycle 2: o_state=RUN and o_pipeline_enable=1 from cycle 3. Counter=5 after 5 enabled edges. i_halt_wb at cycle 8 gives o_halted=1 and enable=0 from cycle 9, and the counter freezes.
2. In IDLE, three i_step pulses spaced 4 cycles apart: enable high for exactly 1 cycle each, o_state returns to IDLE, counter=3.
3. Load-use in RUN, with i_mem_read_id_ex=1, i_rt_id_ex=5, i_rs_if_id=5 for one cycle: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1 that cycle. Repeat with i_rt_id_ex=0: no stall.
4. i_branch_taken=1 with no load match: o_if_id_flush=1. With a simultaneous load match on rt=7: flush=0 and bubble=1, then flush on the following cycle.
5. In HALTED, i_run and i_step are ignored; i_clear gives IDLE with counter 0. Simultaneous i_run+i_step in IDLE gives RUN.
6. Assert i_reset mid-RUN with counter=12: outputs 0 and counter 0 immediately, before the next clock edge. Preload the counter to all-ones and run: it stays all-ones.
